// File: rtl/load_store_unit_if.sv
// Request/response and word-RAM signals of the load/store unit.
// The slave modport is the unit's view and the master modport is the CPU + RAM side.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   // Handshake: a request transfers on a rising edge where req_valid && req_ready.
   // resp_valid is a one-cycle pulse with no backpressure.
   // mem_rdata is combinational for the current mem_addr.
   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit in front of a 1024-word RAM; sub-word stores read-modify-write.
// Define LSU_ALIGN_CHECK_EN to reject misaligned accesses instead of forcing alignment.
module load_store_unit (
   input  logic                  clk,
   input  logic                  rst,
   load_store_unit_if.slave      bus,
   output logic [1:0]            dbg_state
);
   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [11:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        mem_we_q, mem_we_d;
   logic [9:0]  mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;

   logic        req_err;
   logic        align_err;
   logic [11:0] eff_addr;
   logic [31:0] merged;
   logic [31:0] shifted;
   logic [31:0] load_ext;

   always_comb begin
      eff_addr = bus.req_addr[11:0];
`ifdef LSU_ALIGN_CHECK_EN
      align_err = (bus.req_size == SZ_HALF && bus.req_addr[0]) ||
                  (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
      align_err = 1'b0;
      if (bus.req_size == SZ_HALF) eff_addr[0] = 1'b0;
      if (bus.req_size == 2'b10)   eff_addr[1:0] = 2'b00;
`endif
      req_err = (|bus.req_addr[31:12]) || (bus.req_size == 2'b11) || align_err;
   end

   // Lane handling is little-endian on the latched byte offset.
   always_comb begin
      merged  = bus.mem_rdata;
      shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};
      case (size_q)
         SZ_BYTE: begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
         end
         SZ_HALF: begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
         end
         default: begin
            merged   = wdata_q;
            load_ext = bus.mem_rdata;
         end
      endcase
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      uns_d        = uns_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = 10'd0;
      mem_wdata_d  = 32'd0;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'd0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               size_d  = bus.req_size;
               uns_d   = bus.req_unsigned;
               addr_d  = eff_addr;
               wdata_d = bus.req_wdata;
               if (req_err) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (!bus.req_we || bus.req_size != 2'b10) begin
                  state_d    = READ;
                  mem_addr_d = eff_addr[11:2];
               end else begin
                  state_d     = WRITE;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = eff_addr[11:2];
                  mem_wdata_d = bus.req_wdata;
               end
            end
         end
         READ: begin
            if (we_q) begin
               state_d     = WRITE;
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_q[11:2];
               mem_wdata_d = merged;
            end else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_ext;
            end
         end
         WRITE: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         addr_q       <= 12'd0;
         wdata_q      <= 32'd0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 10'd0;
         mem_wdata_q  <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   // Outputs are gated by rst so a reset raised mid-cycle takes effect at once.
   assign bus.req_ready  = (state_q == IDLE) && !rst;
   assign bus.resp_valid = resp_valid_q && !rst;
   assign bus.resp_err   = resp_err_q && !rst;
   assign bus.resp_rdata = rst ? 32'd0 : resp_rdata_q;
   assign bus.mem_we     = mem_we_q && !rst;
   assign bus.mem_addr   = rst ? 10'd0 : mem_addr_q;
   assign bus.mem_wdata  = rst ? 32'd0 : mem_wdata_q;
   assign dbg_state      = state_q;
endmodule
